// File: rtl/sigdel_sched.sv
// Round-robin sample scheduler for the shared sigma-delta modulator.
// Holds each accepted sample for an N-cycle window and reports the modulator ones count.
module sigdel_sched #(
    parameter int unsigned DW    = 8,
    parameter int unsigned OSR_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic [OSR_W-1:0] osr,
    input  logic             req0_valid,
    input  logic [DW-1:0]    req0_data,
    output logic             req0_ready,
    input  logic             req1_valid,
    input  logic [DW-1:0]    req1_data,
    output logic             req1_ready,
    output logic [DW-1:0]    mod_inp,
    output logic             mod_load,
    input  logic             mod_bit,
    output logic             grant_id,
    output logic [OSR_W-1:0] dec_data,
    output logic             dec_id,
    output logic             dec_valid,
    output logic             busy
);

    typedef enum logic {
        IDLE = 1'b0,
        HOLD = 1'b1
    } state_t;

    state_t           state_q, state_d;
    logic [DW-1:0]    mod_inp_q, mod_inp_d;
    logic             mod_load_q, mod_load_d;
    logic             grant_id_q, grant_id_d;
    logic             last_grant_q, last_grant_d;
    logic [OSR_W-1:0] cnt_q, cnt_d;
    logic [OSR_W-1:0] acc_q, acc_d;
    logic [OSR_W-1:0] dec_data_q, dec_data_d;
    logic             dec_id_q, dec_id_d;
    logic             dec_valid_q, dec_valid_d;
    logic             busy_q, busy_d;

    logic             final_c;
    logic             accept_c;
    logic             gsel_c;
    logic [OSR_W-1:0] ones_c;

    // Accept window: idle, or the last cycle of a hold so windows run back-to-back.
    assign final_c  = (state_q == HOLD) && (cnt_q == '0);
    assign accept_c = !rst && en && (req0_valid || req1_valid)
                      && ((state_q == IDLE) || final_c);
    assign gsel_c   = (req0_valid && req1_valid) ? !last_grant_q : req1_valid;
    assign ones_c   = acc_q + OSR_W'(mod_bit);

    assign req0_ready = accept_c && !gsel_c;
    assign req1_ready = accept_c && gsel_c;

    always_comb begin
        state_d      = state_q;
        mod_inp_d    = mod_inp_q;
        mod_load_d   = 1'b0;
        grant_id_d   = grant_id_q;
        last_grant_d = last_grant_q;
        cnt_d        = cnt_q;
        acc_d        = acc_q;
        dec_data_d   = dec_data_q;
        dec_id_d     = dec_id_q;
        dec_valid_d  = 1'b0;
        busy_d       = busy_q;

        if (state_q == HOLD) begin
            if (!final_c) begin
                acc_d = ones_c;
                cnt_d = cnt_q - OSR_W'(1);
            end else begin
                dec_data_d  = ones_c;
                dec_id_d    = grant_id_q;
                dec_valid_d = 1'b1;
                state_d     = IDLE;
                busy_d      = 1'b0;
            end
        end

        // A new accept overrides the return to idle; osr of zero means a one-cycle window.
        if (accept_c) begin
            mod_inp_d    = gsel_c ? req1_data : req0_data;
            grant_id_d   = gsel_c;
            last_grant_d = gsel_c;
            cnt_d        = (osr == '0) ? '0 : osr - OSR_W'(1);
            acc_d        = '0;
            mod_load_d   = 1'b1;
            state_d      = HOLD;
            busy_d       = 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= IDLE;
            mod_inp_q    <= '0;
            mod_load_q   <= 1'b0;
            grant_id_q   <= 1'b0;
            last_grant_q <= 1'b1;
            cnt_q        <= '0;
            acc_q        <= '0;
            dec_data_q   <= '0;
            dec_id_q     <= 1'b0;
            dec_valid_q  <= 1'b0;
            busy_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            mod_inp_q    <= mod_inp_d;
            mod_load_q   <= mod_load_d;
            grant_id_q   <= grant_id_d;
            last_grant_q <= last_grant_d;
            cnt_q        <= cnt_d;
            acc_q        <= acc_d;
            dec_data_q   <= dec_data_d;
            dec_id_q     <= dec_id_d;
            dec_valid_q  <= dec_valid_d;
            busy_q       <= busy_d;
        end
    end

    assign mod_inp   = mod_inp_q;
    assign mod_load  = mod_load_q;
    assign grant_id  = grant_id_q;
    assign dec_data  = dec_data_q;
    assign dec_id    = dec_id_q;
    assign dec_valid = dec_valid_q;
    assign busy      = busy_q;

endmodule

// File: tb/tb_sigdel_sched.sv
// Scoreboard bench for sigdel_sched: directed stimulus pushes expected loads and
// decimated results; a negedge monitor pops and compares on mod_load / dec_valid.
module tb_sigdel_sched;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       en = 1'b0;
    logic [7:0] osr = 8'd0;
    logic       req0_valid = 1'b0;
    logic [7:0] req0_data = 8'd0;
    logic       req0_ready;
    logic       req1_valid = 1'b0;
    logic [7:0] req1_data = 8'd0;
    logic       req1_ready;
    logic [7:0] mod_inp;
    logic       mod_load;
    logic       mod_bit = 1'b0;
    logic       grant_id;
    logic [7:0] dec_data;
    logic       dec_id;
    logic       dec_valid;
    logic       busy;

    int checks = 0;
    int errors = 0;

    logic [8:0] exp_mod_q[$];
    logic [8:0] exp_dec_q[$];

    sigdel_sched #(.DW(8), .OSR_W(8)) dut (
        .clk(clk), .rst(rst), .en(en), .osr(osr),
        .req0_valid(req0_valid), .req0_data(req0_data), .req0_ready(req0_ready),
        .req1_valid(req1_valid), .req1_data(req1_data), .req1_ready(req1_ready),
        .mod_inp(mod_inp), .mod_load(mod_load), .mod_bit(mod_bit),
        .grant_id(grant_id), .dec_data(dec_data), .dec_id(dec_id),
        .dec_valid(dec_valid), .busy(busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic nxt();
        @(posedge clk);
        #1;
    endtask

    task automatic smp();
        @(negedge clk);
    endtask

    task automatic chk_cleared(input string tag);
        chk({tag, ".mod_inp"}, 32'(mod_inp), 32'h0);
        chk({tag, ".mod_load"}, 32'(mod_load), 32'h0);
        chk({tag, ".grant_id"}, 32'(grant_id), 32'h0);
        chk({tag, ".dec_data"}, 32'(dec_data), 32'h0);
        chk({tag, ".dec_id"}, 32'(dec_id), 32'h0);
        chk({tag, ".dec_valid"}, 32'(dec_valid), 32'h0);
        chk({tag, ".busy"}, 32'(busy), 32'h0);
        chk({tag, ".req0_ready"}, 32'(req0_ready), 32'h0);
        chk({tag, ".req1_ready"}, 32'(req1_ready), 32'h0);
    endtask

    // Monitor: every load and every decimated result must match the next expectation.
    always @(negedge clk) begin
        if (!rst) begin
            if (mod_load) begin
                if (exp_mod_q.size() == 0) begin
                    checks++; errors++;
                    $display("FAIL mod_load_unexpected: got id=%0d inp=%0h expected none", grant_id, mod_inp);
                end else begin
                    logic [8:0] e;
                    e = exp_mod_q.pop_front();
                    chk("load.grant_id", 32'(grant_id), 32'(e[8]));
                    chk("load.mod_inp", 32'(mod_inp), 32'(e[7:0]));
                end
            end
            if (dec_valid) begin
                if (exp_dec_q.size() == 0) begin
                    checks++; errors++;
                    $display("FAIL dec_unexpected: got id=%0d data=%0d expected none", dec_id, dec_data);
                end else begin
                    logic [8:0] e;
                    e = exp_dec_q.pop_front();
                    chk("dec.dec_id", 32'(dec_id), 32'(e[8]));
                    chk("dec.dec_data", 32'(dec_data), 32'(e[7:0]));
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        logic b3[9];
        logic b8[8];
        b3 = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0};
        b8 = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0};

        // Reset with random inputs, en low
        #1;
        for (int i = 0; i < 3; i++) begin
            req0_valid = 1'($urandom_range(0, 1));
            req1_valid = 1'($urandom_range(0, 1));
            req0_data  = 8'($urandom_range(0, 255));
            req1_data  = 8'($urandom_range(0, 255));
            mod_bit    = 1'($urandom_range(0, 1));
            osr        = 8'($urandom_range(0, 255));
            smp();
            chk_cleared("reset");
            nxt();
        end
        rst = 1'b0;
        smp();
        chk_cleared("post_reset");
        nxt();

        // Single req0, osr=4, mod_bit=1
        req0_valid = 1'b1; req1_valid = 1'b0; req0_data = 8'h80;
        osr = 8'd4; en = 1'b1; mod_bit = 1'b1;
        exp_mod_q.push_back({1'b0, 8'h80});
        exp_dec_q.push_back({1'b0, 8'd4});
        smp();
        chk("t2.req0_ready", 32'(req0_ready), 32'h1);
        chk("t2.req1_ready", 32'(req1_ready), 32'h0);
        nxt();
        req0_valid = 1'b0;
        for (int k = 1; k <= 4; k++) begin
            smp();
            chk("t2.busy", 32'(busy), 32'h1);
            chk("t2.mod_load", 32'(mod_load), 32'(k == 1));
            chk("t2.mod_inp", 32'(mod_inp), 32'h80);
            nxt();
        end
        smp();
        chk("t2.busy_end", 32'(busy), 32'h0);
        chk("t2.dec_valid", 32'(dec_valid), 32'h1);
        nxt();

        // Both valid, osr=2: alternating grants starting with channel 0
        rst = 1'b1; nxt(); rst = 1'b0;
        osr = 8'd2; req0_data = 8'h11; req1_data = 8'h22;
        for (int w = 0; w < 4; w++)
            exp_mod_q.push_back((w % 2 == 0) ? {1'b0, 8'h11} : {1'b1, 8'h22});
        exp_dec_q.push_back({1'b0, 8'd2});
        exp_dec_q.push_back({1'b1, 8'd1});
        exp_dec_q.push_back({1'b0, 8'd0});
        exp_dec_q.push_back({1'b1, 8'd1});
        for (int c = 0; c <= 8; c++) begin
            req0_valid = (c <= 6);
            req1_valid = (c <= 6);
            mod_bit    = b3[c];
            smp();
            if (c % 2 == 0 && c <= 6) begin
                chk("t3.req0_ready", 32'(req0_ready), 32'((c / 2) % 2 == 0));
                chk("t3.req1_ready", 32'(req1_ready), 32'((c / 2) % 2 == 1));
            end
            if (c >= 1) chk("t3.busy", 32'(busy), 32'h1);
            nxt();
        end
        mod_bit = 1'b0;
        smp();
        chk("t3.busy_end", 32'(busy), 32'h0);
        nxt();

        // osr=8 on req1 with a patterned bitstream; osr change mid-window ignored
        req1_valid = 1'b1; req1_data = 8'h5A; osr = 8'd8;
        exp_mod_q.push_back({1'b1, 8'h5A});
        exp_dec_q.push_back({1'b1, 8'd4});
        smp();
        chk("t4.req1_ready", 32'(req1_ready), 32'h1);
        nxt();
        req1_valid = 1'b0;
        for (int c = 1; c <= 8; c++) begin
            mod_bit = b8[c - 1];
            if (c == 2) osr = 8'd3;
            smp();
            chk("t4.busy", 32'(busy), 32'h1);
            nxt();
        end
        mod_bit = 1'b0;
        smp();
        chk("t4.busy_end", 32'(busy), 32'h0);
        nxt();

        // osr=0 behaves as a one-cycle window, back-to-back
        osr = 8'd0; req0_valid = 1'b1; req0_data = 8'h33; mod_bit = 1'b1;
        exp_mod_q.push_back({1'b0, 8'h33});
        exp_mod_q.push_back({1'b0, 8'h33});
        exp_dec_q.push_back({1'b0, 8'd1});
        exp_dec_q.push_back({1'b0, 8'd1});
        smp();
        chk("t4z.req0_ready0", 32'(req0_ready), 32'h1);
        nxt();
        smp();
        chk("t4z.busy1", 32'(busy), 32'h1);
        chk("t4z.req0_ready1", 32'(req0_ready), 32'h1);
        nxt();
        req0_valid = 1'b0;
        smp();
        chk("t4z.busy2", 32'(busy), 32'h1);
        chk("t4z.mod_load2", 32'(mod_load), 32'h1);
        nxt();
        smp();
        chk("t4z.busy3", 32'(busy), 32'h0);
        nxt();

        // en dropped in the 2nd hold cycle with req1 pending
        osr = 8'd4; mod_bit = 1'b0; req0_valid = 1'b1; req0_data = 8'h44;
        exp_mod_q.push_back({1'b0, 8'h44});
        exp_dec_q.push_back({1'b0, 8'd0});
        smp();
        chk("t5.req0_ready", 32'(req0_ready), 32'h1);
        nxt();
        req0_valid = 1'b0; req1_valid = 1'b1; req1_data = 8'h99;
        smp();
        chk("t5.req1_ready_c1", 32'(req1_ready), 32'h0);
        nxt();
        en = 1'b0;
        for (int c = 2; c <= 6; c++) begin
            smp();
            chk("t5.req1_ready", 32'(req1_ready), 32'h0);
            if (c == 5) chk("t5.dec_valid", 32'(dec_valid), 32'h1);
            if (c >= 5) chk("t5.busy", 32'(busy), 32'h0);
            nxt();
        end
        en = 1'b1; mod_bit = 1'b1;
        exp_mod_q.push_back({1'b1, 8'h99});
        exp_dec_q.push_back({1'b1, 8'd4});
        smp();
        chk("t5.req1_ready_reen", 32'(req1_ready), 32'h1);
        nxt();
        req1_valid = 1'b0;
        for (int c = 0; c < 6; c++) begin
            smp(); nxt();
        end

        // Reset in the 3rd hold cycle aborts the window silently
        req0_valid = 1'b1; req0_data = 8'h66; mod_bit = 1'b1;
        exp_mod_q.push_back({1'b0, 8'h66});
        smp();
        chk("t6.req0_ready", 32'(req0_ready), 32'h1);
        nxt();
        req0_valid = 1'b0;
        smp(); nxt();
        smp(); nxt();
        rst = 1'b1;
        #1;
        chk("t6.busy_async", 32'(busy), 32'h0);
        chk("t6.mod_inp_async", 32'(mod_inp), 32'h0);
        chk("t6.grant_async", 32'(grant_id), 32'h0);
        nxt();
        rst = 1'b0;
        for (int c = 0; c < 6; c++) begin
            smp();
            chk("t6.idle_busy", 32'(busy), 32'h0);
            nxt();
        end
        req0_valid = 1'b1; req1_valid = 1'b1; req0_data = 8'h11; req1_data = 8'h22;
        mod_bit = 1'b0;
        exp_mod_q.push_back({1'b0, 8'h11});
        exp_dec_q.push_back({1'b0, 8'd0});
        smp();
        chk("t6.tie_req0_ready", 32'(req0_ready), 32'h1);
        chk("t6.tie_req1_ready", 32'(req1_ready), 32'h0);
        nxt();
        req0_valid = 1'b0; req1_valid = 1'b0;
        for (int c = 0; c < 7; c++) begin
            smp(); nxt();
        end

        chk("end.mod_queue_empty", 32'(exp_mod_q.size()), 32'h0);
        chk("end.dec_queue_empty", 32'(exp_dec_q.size()), 32'h0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/sigdel_sched.md
Name: sigdel_sched

Overview:
Sample scheduler for the shared sigma-delta modulator. Two sample sources compete for the modulator input. The scheduler picks one round-robin, loads its 8-bit value into the modulator and holds it for a programmable oversampling window. During the window it counts the modulator's output ones and returns that count per channel as a coarse decimated readback. It sits between the tile pins or register logic and the sigdel datapath inside the top-level tile.

Parameters:
DW, 8, sample and modulator input width
OSR_W, 8, width of the oversampling-ratio field, hold counter and ones counter

Ports:
clk  in  1  system clock
rst  in  1  asynchronous active-high reset
en  in  1  run enable; gates acceptance of new samples
osr  in  OSR_W  window length N in cycles; 0 is treated as 1
req0_valid  in  1  channel 0 has a sample
req0_data  in  DW  channel 0 sample
req0_ready  out  1  channel 0 sample accepted this cycle
req1_valid  in  1  channel 1 has a sample
req1_data  in  DW  channel 1 sample
req1_ready  out  1  channel 1 sample accepted this cycle
mod_inp  out  DW  registered modulator input
mod_load  out  1  one-cycle pulse in the first cycle a new mod_inp is applied
mod_bit  in  1  modulator output bitstream
grant_id  out  1  channel owning the current mod_inp
dec_data  out  OSR_W  ones count of the last completed window
dec_id  out  1  channel of dec_data
dec_valid  out  1  one-cycle pulse; dec_data/dec_id are new
busy  out  1  high while state is HOLD

Behaviour:
- Reset (async assert, sync release): state IDLE; mod_inp=0, mod_load=0, grant_id=0, dec_data=0, dec_id=0, dec_valid=0, busy=0. last_grant=1, so the first tie goes to channel 0. Counters are 0.
- States are IDLE and HOLD.
- Accept condition: en=1 and (req0_valid or req1_valid), evaluated in IDLE or in the final HOLD cycle.
- Arbitration:
  - Only one channel valid: that channel is granted.
  - Both valid: the channel not equal to last_grant is granted.
- reqX_ready is combinational and high only in the accept cycle, for the granted channel. Transfer occurs on valid and ready in the same cycle. Ready never depends on ready.
- On the accept edge:
  - mod_inp<=data, grant_id<=X, last_grant<=X
  - N latched from osr, with 0 mapped to 1; cnt<=N-1; acc<=0
  - mod_load<=1; state<=HOLD
- HOLD, every cycle:
  - mod_bit is sampled.
  - mod_load is high in the first HOLD cycle only.
  - Not final (cnt!=0): acc+=mod_bit, cnt-=1.
  - Final cycle (cnt==0):
    - dec_data<=acc+mod_bit, dec_id<=grant_id, dec_valid<=1 for exactly one cycle.
    - If the accept condition holds: accept back-to-back, with no idle cycle.
    - Otherwise: state<=IDLE.
- Window timing: exactly N HOLD cycles per sample. dec_valid appears in the cycle after the final HOLD cycle. Latency from accept edge to dec_valid is N+1 cycles.
- mod_inp holds its value in IDLE; the modulator keeps running on the last sample.
- osr changes mid-window have no effect until the next accept.
- en=0 mid-HOLD: the current window completes and reports; no new accept follows.
- Input valids may drop without handshake; only the accept cycle matters.
- The ones count never overflows: max N = 2^OSR_W-1 fits OSR_W bits.
- dec_valid has no backpressure; an unread result is overwritten by the next pulse.
- Reset mid-HOLD: immediate clear; no dec_valid is generated for the aborted window.

Test Plan:
- Reset with random inputs: all outputs 0 while rst=1 and in the first cycle after release. req0_ready=req1_ready=0 while en=0.
- osr=4, mod_bit=1, single req0 0x80: req0_ready high one cycle (T0); mod_inp=0x80 and mod_load=1 in T1; busy T1–T4; dec_valid in T5 with dec_data=4, dec_id=0.
- Both valid continuously, osr=2, data 0x11/0x22: grants alternate 0,1,0,1 starting with 0. mod_load every 2 cycles, no idle gaps. dec_id alternates, dec_data matches the mod_bit pattern.
- osr=8, mod_bit sequence 1,0,1,1,0,0,1,0 in window: dec_data=4. Also osr=0 with mod_bit=1: windows of 1 cycle, dec_data=1 each.
- en dropped in 2nd HOLD cycle with req1_valid high, osr=4: window completes, dec_valid fires, state IDLE, no further ready. Re-raising en accepts req1.
- rst pulsed in 3rd HOLD cycle: outputs clear asynchronously, no dec_valid afterward. Then both valid: channel 0 wins first.
